// File: rtl/pll_seq_pkg.sv
// Shared state encoding and counter sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PWRDN = 3'd0,
        RST   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4,
        FAULT = 3'd5
    } seq_state_t;

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs; resets to zero.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLLA power/reset sequencing, lock qualification with timeout/retry, fault latch
// and lock-loss recovery; produces the reset for logic clocked by the PLL output.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PWD_CYCLES    = 16,
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned LOCK_STABLE   = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned RELEASE_DELAY = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pll_lock_i,
    input  logic                               restart,
    output logic                               pll_pwd,
    output logic                               pll_reset,
    output logic                               sys_reset,
    output logic                               locked,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retries,
    output logic [7:0]                         lock_loss_cnt
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int unsigned PH_MAX  = max2(max2(PWD_CYCLES, RST_CYCLES),
                                           max2(LOCK_TIMEOUT, RELEASE_DELAY));
    localparam int unsigned PH_W    = cnt_w(PH_MAX);
    localparam int unsigned ST_W    = cnt_w(LOCK_STABLE);

    seq_state_t         state_q,   state_d;
    logic [PH_W-1:0]    phase_q,   phase_d;
    logic [ST_W-1:0]    stable_q,  stable_d;
    logic [RETRY_W-1:0] retries_q, retries_d;
    logic [7:0]         llc_q,     llc_d;
    logic               pwd_q,     pwd_d;
    logic               prst_q,    prst_d;
    logic               sysr_q,    sysr_d;
    logic               locked_q,  locked_d;
    logic               fault_q,   fault_d;
    logic               lock_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PWRDN;
            phase_q   <= '0;
            stable_q  <= '0;
            retries_q <= '0;
            llc_q     <= '0;
            pwd_q     <= 1'b1;
            prst_q    <= 1'b1;
            sysr_q    <= 1'b1;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            stable_q  <= stable_d;
            retries_q <= retries_d;
            llc_q     <= llc_d;
            pwd_q     <= pwd_d;
            prst_q    <= prst_d;
            sysr_q    <= sysr_d;
            locked_q  <= locked_d;
            fault_q   <= fault_d;
        end
    end

    // The phase counter times PWRDN, RST, HOLD and doubles as the WAIT timeout.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + PH_W'(1);
        stable_d  = stable_q;
        retries_d = retries_q;
        llc_d     = llc_q;

        if (restart) begin
            state_d   = PWRDN;
            phase_d   = '0;
            stable_d  = '0;
            retries_d = '0;
        end else begin
            unique case (state_q)
                PWRDN: begin
                    if (phase_q == PH_W'(PWD_CYCLES - 1)) begin
                        state_d = RST;
                        phase_d = '0;
                    end
                end
                RST: begin
                    if (phase_q == PH_W'(RST_CYCLES - 1)) begin
                        state_d  = WAIT;
                        phase_d  = '0;
                        stable_d = '0;
                    end
                end
                WAIT: begin
                    stable_d = lock_s ? stable_q + ST_W'(1) : '0;
                    if (lock_s && (stable_q == ST_W'(LOCK_STABLE - 1))) begin
                        state_d = HOLD;
                        phase_d = '0;
                    end else if (phase_q == PH_W'(LOCK_TIMEOUT - 1)) begin
                        phase_d = '0;
                        if (retries_q == RETRY_W'(MAX_RETRIES)) begin
                            state_d = FAULT;
                        end else begin
                            state_d   = RST;
                            retries_d = retries_q + RETRY_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state_d  = WAIT;
                        phase_d  = '0;
                        stable_d = '0;
                    end else if (phase_q == PH_W'(RELEASE_DELAY - 1)) begin
                        state_d = RUN;
                        phase_d = '0;
                    end
                end
                RUN: begin
                    phase_d = phase_q;
                    if (!lock_s) begin
                        state_d   = RST;
                        phase_d   = '0;
                        retries_d = '0;
                        if (llc_q != 8'hFF) begin
                            llc_d = llc_q + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    phase_d = phase_q;
                end
                default: begin
                    state_d = PWRDN;
                    phase_d = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they change on the entering edge.
        pwd_d    = (state_d == PWRDN) || (state_d == FAULT);
        prst_d   = (state_d == PWRDN) || (state_d == RST) || (state_d == FAULT);
        sysr_d   = (state_d != RUN);
        locked_d = (state_d == RUN);
        fault_d  = (state_d == FAULT);
    end

    assign pll_pwd       = pwd_q;
    assign pll_reset     = prst_q;
    assign sys_reset     = sysr_q;
    assign locked        = locked_q;
    assign fault         = fault_q;
    assign retries       = retries_q;
    assign lock_loss_cnt = llc_q;

endmodule
